store_rmw_unit: RTL

Partial-store writer for the multicycle CPU, and the write-side counterpart of the load-side byte/halfword extractor. It accepts a store request (word, halfword or byte) from the controller and drives the word-wide memory. Sub-word stores use a read-modify-write sequence on the containing aligned word. It sits between the B-register/ALU-out path and the memory port, so the CPU sees one start/done handshake per store.

---
 rtl/store_rmw_unit.sv | 115 +++++++++++
 1 files changed

// File: rtl/store_rmw_unit.sv
// rtl/store_rmw_unit.sv - partial-store writer: word writes directly, byte/halfword via read-modify-write
// Optional feature macro: STORE_MISALIGN_TRAP_EN (reject odd-address halfword stores with Err).
module store_rmw_unit #(
  parameter int MEM_LAT = 1
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Start,
  input  logic [1:0]  Size,
  input  logic [31:0] Addr,
  input  logic [31:0] Data,
  output logic        Busy,
  output logic        Done,
  output logic        Err,
  output logic [31:0] MemAddr,
  output logic        MemWr,
  output logic [31:0] MemDataOut,
  input  logic [31:0] MemDataIn
);

  typedef enum logic [2:0] {IDLE, READ, MERGE, WRITE, DONE} state_t;

  localparam logic [1:0] SZ_WORD = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_BYTE = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;
  localparam logic [2:0] LAT_LAST = 3'(MEM_LAT - 1);

  state_t      state, state_nxt;
  logic [31:0] a_q, d_q, w_q, m_q;
  logic [1:0]  s_q;
  logic [2:0]  lat_q;
  logic        err_q;
  logic        misalign, reject;
  logic [31:0] merged;

`ifdef STORE_MISALIGN_TRAP_EN
  assign misalign = (Size == SZ_HALF) && Addr[0];
`else
  assign misalign = 1'b0;
`endif
  assign reject = (Size == SZ_RSVD) || misalign;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (Start) begin
          if (reject)                state_nxt = DONE;
          else if (Size == SZ_WORD)  state_nxt = WRITE;
          else                       state_nxt = READ;
        end
      end
      READ:    if (lat_q == LAT_LAST) state_nxt = MERGE;
      MERGE:   state_nxt = WRITE;
      WRITE:   state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Little-endian lane replacement; halfword lane choice ignores A[0].
  always_comb begin
    merged = w_q;
    if (s_q == SZ_BYTE) begin
      case (a_q[1:0])
        2'd0:    merged[7:0]   = d_q[7:0];
        2'd1:    merged[15:8]  = d_q[7:0];
        2'd2:    merged[23:16] = d_q[7:0];
        default: merged[31:24] = d_q[7:0];
      endcase
    end else if (a_q[1]) begin
      merged[31:16] = d_q[15:0];
    end else begin
      merged[15:0] = d_q[15:0];
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state <= IDLE;
      a_q   <= '0;
      d_q   <= '0;
      s_q   <= '0;
      w_q   <= '0;
      m_q   <= '0;
      lat_q <= '0;
      err_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && Start) begin
        a_q   <= Addr;
        d_q   <= Data;
        s_q   <= Size;
        err_q <= reject;
      end
      if (state == READ) begin
        lat_q <= lat_q + 3'd1;
        if (lat_q == LAT_LAST) w_q <= MemDataIn;
      end else begin
        lat_q <= '0;
      end
      if (state == MERGE) m_q <= merged;
    end
  end

  // Outputs decode straight from state so reset removes MemWr without waiting for a clock.
  assign Busy       = (state != IDLE);
  assign Done       = (state == DONE);
  assign Err        = (state == DONE) && err_q;
  assign MemWr      = (state == WRITE);
  assign MemAddr    = (state == IDLE) ? 32'd0 : {a_q[31:2], 2'b00};
  assign MemDataOut = (state != WRITE) ? 32'd0 : ((s_q == SZ_WORD) ? d_q : m_q);

endmodule
